// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream arbiter.
// State encoding plus a constant-foldable clog2.
package axis_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bus bundle between the byte requesters, the arbiter and the packer.
// slave is the arbiter's view; master is the surrounding system's view.
interface axis_rr_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int DW      = 8
) ();
   import axis_pkg::*;

   localparam int IDW = clog2(NUM_SRC);

   logic [NUM_SRC*DW-1:0] s_tdata;
   logic [NUM_SRC-1:0]    s_tvalid;
   logic [NUM_SRC-1:0]    s_tlast;
   logic [NUM_SRC-1:0]    s_tready;
   logic [DW-1:0]         m_tdata;
   logic                  m_tvalid;
   logic                  m_tready;
   logic                  m_tlast;
   logic [IDW-1:0]        m_tid;
   logic                  trunc_pulse;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast,
      output m_tid, trunc_pulse
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast,
      input  m_tid, trunc_pulse
   );

endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Rotating priority finder: first set request at or after ptr,
// wrapping modulo NUM_SRC.
module rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [IDW-1:0]     idx,
   output logic               any
);

   int i;

   // Scan offsets high to low so the smallest offset from ptr wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      i   = 0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         i = int'(ptr) + k;
         if (i >= NUM_SRC) i = i - NUM_SRC;
         if (req[i]) begin
            idx = IDW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter feeding one byte-stream sink.
// Holds a grant until last (or the beat limit) and registers the output.
module axis_rr_arbiter
   import axis_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int DW        = 8,
   parameter int MAX_BEATS = 64
) (
   input  logic              clk,
   input  logic              reset,
   axis_rr_arbiter_if.slave  bus
);

   localparam int IDW = clog2(NUM_SRC);
   localparam int CW  = clog2(MAX_BEATS + 1);

   state_e         state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
   logic [DW-1:0]  m_tdata_q, m_tdata_d;
   logic           m_tvalid_q, m_tvalid_d;
   logic           m_tlast_q, m_tlast_d;
   logic [IDW-1:0] m_tid_q, m_tid_d;
   logic           trunc_q, trunc_d;

   logic [IDW-1:0]     pick_idx;
   logic               pick_any;
   logic               sel_valid;
   logic               sel_last;
   logic [DW-1:0]      sel_data;
   logic               grant_rdy;
   logic               accept;
   logic               cnt_max;
   logic [NUM_SRC-1:0] s_tready_c;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDW     (IDW)
   ) u_pick (
      .req (bus.s_tvalid),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Granted-source view and the handshake back to it.
   always_comb begin
      sel_valid  = bus.s_tvalid[grant_q];
      sel_last   = bus.s_tlast[grant_q];
      sel_data   = bus.s_tdata[grant_q*DW +: DW];
      grant_rdy  = (state_q == ST_BUSY) &&
                   (!m_tvalid_q || bus.m_tready);
      accept     = grant_rdy && sel_valid;
      cnt_max    = (beat_cnt_q == CW'(MAX_BEATS - 1));
      s_tready_c = '0;
      if (grant_rdy) s_tready_c[grant_q] = 1'b1;
   end

   // Next-state: arbitration, beat counting and output register load.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      beat_cnt_d = beat_cnt_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_tid_d    = m_tid_q;
      m_tvalid_d = m_tvalid_q;
      trunc_d    = 1'b0;

      if (bus.m_tready) m_tvalid_d = 1'b0;

      if (accept) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = sel_data;
         m_tid_d    = grant_q;
         m_tlast_d  = sel_last || cnt_max;
         trunc_d    = !sel_last && cnt_max;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (sel_last || cnt_max) begin
                  state_d = ST_IDLE;
                  if (grant_q == IDW'(NUM_SRC - 1))
                     ptr_d = '0;
                  else
                     ptr_d = grant_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops any held beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         beat_cnt_q <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tid_q    <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         beat_cnt_q <= beat_cnt_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tid_q    <= m_tid_d;
         trunc_q    <= trunc_d;
      end
   end

   assign bus.s_tready    = s_tready_c;
   assign bus.m_tdata     = m_tdata_q;
   assign bus.m_tvalid    = m_tvalid_q;
   assign bus.m_tlast     = m_tlast_q;
   assign bus.m_tid       = m_tid_q;
   assign bus.trunc_pulse = trunc_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter with MAX_BEATS = 4.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_axis_rr_arbiter;

   localparam int NS = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   axis_rr_arbiter_if #(.NUM_SRC(NS), .DW(DW)) bus ();

   axis_rr_arbiter #(
      .NUM_SRC   (NS),
      .DW        (DW),
      .MAX_BEATS (MB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic src(input int i, input logic [7:0] d, input logic l);
      bus.s_tdata[i*DW +: DW] = d;
      bus.s_tlast[i]          = l;
   endtask

   task automatic chk_out(input string tag, input logic v,
                          input logic [7:0] d, input logic [1:0] id,
                          input logic l);
      chk({tag, ".tvalid"}, 32'(bus.m_tvalid), 32'(v));
      chk({tag, ".tdata"},  32'(bus.m_tdata),  32'(d));
      chk({tag, ".tid"},    32'(bus.m_tid),    32'(id));
      chk({tag, ".tlast"},  32'(bus.m_tlast),  32'(l));
   endtask

   logic [31:0] word;
   int          words;

   initial begin
      reset        = 1'b1;
      bus.s_tdata  = '0;
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      bus.m_tready = 1'b1;
      step();
      step();
      chk_out("rst", 1'b0, 8'h00, 2'd0, 1'b0);
      chk("rst.tready", 32'(bus.s_tready), 32'h0);
      chk("rst.trunc", 32'(bus.trunc_pulse), 32'h0);
      chk("rst.ptr", 32'(dut.ptr_q), 32'h0);
      reset = 1'b0;
      step();

      // rotation: sources 0,1,3 with 1-beat packets
      src(0, 8'hA0, 1'b1);
      src(1, 8'hA1, 1'b1);
      src(3, 8'hA3, 1'b1);
      bus.s_tvalid = 4'b1011;
      step();
      chk("rot.tready0", 32'(bus.s_tready), 32'b0001);
      step();
      chk_out("rot0", 1'b1, 8'hA0, 2'd0, 1'b1);
      step();
      chk("rot.gap1", 32'(bus.m_tvalid), 32'h0);
      chk("rot.tready1", 32'(bus.s_tready), 32'b0010);
      step();
      chk_out("rot1", 1'b1, 8'hA1, 2'd1, 1'b1);
      step();
      chk("rot.gap2", 32'(bus.m_tvalid), 32'h0);
      step();
      chk_out("rot2", 1'b1, 8'hA3, 2'd3, 1'b1);
      step();
      chk("rot.gap3", 32'(bus.m_tvalid), 32'h0);
      step();
      chk_out("rot3", 1'b1, 8'hA0, 2'd0, 1'b1);
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      step();
      chk("rot.ptr", 32'(dut.ptr_q), 32'h1);

      // single request from source 2
      src(2, 8'h68, 1'b0);
      bus.s_tvalid = 4'b0100;
      #1;
      chk("one.idle_rdy", 32'(bus.s_tready), 32'h0);
      step();
      chk("one.grant_rdy", 32'(bus.s_tready), 32'b0100);
      step();
      chk_out("one.b1", 1'b1, 8'h68, 2'd2, 1'b0);
      src(2, 8'h69, 1'b0);
      step();
      chk_out("one.b2", 1'b1, 8'h69, 2'd2, 1'b0);
      src(2, 8'h6A, 1'b1);
      step();
      chk_out("one.b3", 1'b1, 8'h6A, 2'd2, 1'b1);
      chk("one.ptr", 32'(dut.ptr_q), 32'h3);
      bus.s_tvalid = '0;
      src(2, 8'h00, 1'b0);
      step();
      chk("one.drain", 32'(bus.m_tvalid), 32'h0);

      // backpressure on source 0
      src(0, 8'h10, 1'b0);
      bus.s_tvalid = 4'b0001;
      step();
      step();
      chk_out("bp.b1", 1'b1, 8'h10, 2'd0, 1'b0);
      src(0, 8'h11, 1'b0);
      bus.m_tready = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp.stall_rdy", 32'(bus.s_tready), 32'h0);
         step();
         chk_out("bp.hold", 1'b1, 8'h10, 2'd0, 1'b0);
      end
      bus.m_tready = 1'b1;
      #1;
      chk("bp.release_rdy", 32'(bus.s_tready), 32'b0001);
      step();
      chk_out("bp.b2", 1'b1, 8'h11, 2'd0, 1'b0);
      src(0, 8'h12, 1'b1);
      step();
      chk_out("bp.b3", 1'b1, 8'h12, 2'd0, 1'b1);
      bus.s_tvalid = '0;
      src(0, 8'h00, 1'b0);
      step();
      chk("bp.drain", 32'(bus.m_tvalid), 32'h0);

      // truncation: source 1 streams 6 beats with no last
      src(1, 8'h21, 1'b0);
      bus.s_tvalid = 4'b0010;
      step();
      for (int k = 1; k <= 4; k++) begin
         src(1, 8'(8'h20 + k), 1'b0);
         step();
         chk_out("tr.beat", 1'b1, 8'(8'h20 + k), 2'd1, k == 4);
         chk("tr.pulse", 32'(bus.trunc_pulse), 32'(k == 4));
      end
      src(1, 8'h25, 1'b0);
      #1;
      chk("tr.idle_rdy", 32'(bus.s_tready), 32'h0);
      step();
      chk("tr.gap", 32'(bus.m_tvalid), 32'h0);
      chk("tr.pulse_off", 32'(bus.trunc_pulse), 32'h0);
      step();
      chk_out("tr.b5", 1'b1, 8'h25, 2'd1, 1'b0);
      src(1, 8'h26, 1'b1);
      step();
      chk_out("tr.b6", 1'b1, 8'h26, 2'd1, 1'b1);
      chk("tr.b6_pulse", 32'(bus.trunc_pulse), 32'h0);
      bus.s_tvalid = '0;
      src(1, 8'h00, 1'b0);
      step();

      // reset after beat 2 of a 4-beat packet from source 3
      src(3, 8'h31, 1'b0);
      bus.s_tvalid = 4'b1000;
      step();
      step();
      chk_out("rm.b1", 1'b1, 8'h31, 2'd3, 1'b0);
      src(3, 8'h32, 1'b0);
      step();
      chk_out("rm.b2", 1'b1, 8'h32, 2'd3, 1'b0);
      src(3, 8'h33, 1'b0);
      reset = 1'b1;
      step();
      chk_out("rm.rst", 1'b0, 8'h00, 2'd0, 1'b0);
      chk("rm.tready", 32'(bus.s_tready), 32'h0);
      chk("rm.ptr", 32'(dut.ptr_q), 32'h0);
      reset = 1'b0;
      src(0, 8'h40, 1'b1);
      src(3, 8'h33, 1'b1);
      bus.s_tvalid = 4'b1001;
      step();
      chk("rm.grant0", 32'(bus.s_tready), 32'b0001);
      step();
      chk_out("rm.p0", 1'b1, 8'h40, 2'd0, 1'b1);
      step();
      step();
      chk_out("rm.p3", 1'b1, 8'h33, 2'd3, 1'b1);
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      step();

      // end to end into a 8->32 packer model
      word  = '0;
      words = 0;
      src(0, 8'h01, 1'b0);
      bus.s_tvalid = 4'b0001;
      step();
      for (int k = 1; k <= 4; k++) begin
         src(0, 8'(k), k == 4);
         step();
         chk("e2e.valid", 32'(bus.m_tvalid), 32'h1);
         word = word | (32'(bus.m_tdata) << (8 * (k - 1)));
         if (bus.m_tvalid && bus.m_tlast) words++;
      end
      chk("e2e.trunc", 32'(bus.trunc_pulse), 32'h0);
      bus.s_tvalid = '0;
      src(0, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         if (bus.m_tvalid && bus.m_tlast) words++;
      end
      chk("e2e.word", word, 32'h04030201);
      chk("e2e.words", 32'(words), 32'h1);
      chk("e2e.idle", 32'(bus.m_tvalid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin, packet-locked AXI-Stream arbiter that shares one byte-stream sink (the 8-bit input of the `axis_reg` width packer) among `NUM_SRC` byte-stream requesters. A grant is held from the first beat of a packet through its `last` beat, so packets from different sources are never interleaved. The output carries the source index (`m_tid`) alongside the data, and one register stage sits between the arbiter and the packer. A beat-count limit forcibly ends runaway packets so that one source cannot hold the packer indefinitely.

## Interface
Parameters:
- `NUM_SRC`, 4, number of requesters; must be at least 2.
- `DW`, 8, data width per beat, equal to the packer's `DW_IN`.
- `MAX_BEATS`, 64, maximum beats per packet before a forced end; must be at least 1.
- `IDW`, $clog2(NUM_SRC), width of the source index (derived; not set by the user).

Ports:
- `clk`  in  1  Single clock; all logic is rising-edge.
- `reset`  in  1  Synchronous, active-high reset.
- `s_tdata`  in  NUM_SRC*DW  Per-source data, packed; source i occupies bits [i*DW +: DW].
- `s_tvalid`  in  NUM_SRC  Per-source valid.
- `s_tlast`  in  NUM_SRC  Per-source end-of-packet.
- `s_tready`  out  NUM_SRC  Per-source ready; at most one bit is high in any cycle.
- `m_tdata`  out  DW  Data to the packer's `s_tdata`.
- `m_tvalid`  out  1  Valid to the packer's `s_tvalid`.
- `m_tready`  in  1  Ready from the packer's `s_tready`.
- `m_tlast`  out  1  End of packet, to the packer's `last`.
- `m_tid`  out  IDW  Source index of the current beat.
- `trunc_pulse`  out  1  One-cycle pulse when a packet is force-terminated.

## Operation
- State machine with two states, IDLE and BUSY. Registers: `grant` (IDW), `ptr` (IDW), `beat_cnt` ($clog2(MAX_BEATS+1) bits), and the output register stage (`m_tdata`, `m_tvalid`, `m_tlast`, `m_tid`).
- **IDLE:**
  - If any `s_tvalid` is high, set `grant` to the first index i, searching from `ptr` upward and wrapping modulo NUM_SRC, whose `s_tvalid[i]` is high.
  - Load `beat_cnt` with 0 and go to BUSY.
  - All `s_tready` bits are 0 while in IDLE.
- **BUSY:**
  - `s_tready[grant] = !m_tvalid || m_tready`; every other `s_tready` bit is 0.
  - An input beat is accepted when `s_tvalid[grant]` and `s_tready[grant]` are both high. On acceptance:
    - The output register loads `s_tdata[grant]`, `m_tid = grant`, and `m_tvalid = 1`.
    - `m_tlast = s_tlast[grant] || (beat_cnt == MAX_BEATS-1)`.
    - `beat_cnt` increments.
- **End of packet:**
  - When the accepted beat has `m_tlast` set: go to IDLE and set `ptr = (grant+1) mod NUM_SRC`. The wrap uses an explicit compare, not a power-of-two mask.
  - If the end was forced (`s_tlast[grant]` low while `beat_cnt == MAX_BEATS-1`), pulse `trunc_pulse` in the same cycle. The source's remaining beats are then arbitrated as a new packet.
- **Output register:**
  - `m_tvalid` clears when `m_tready` is high and no new beat is loaded in that cycle.
  - Output data, `m_tlast` and `m_tid` are held stable while `m_tvalid && !m_tready`.
- **Source behaviour:**
  - A source that drops `s_tvalid` mid-packet keeps the grant; the arbiter stalls until that source resumes.
  - A lone requester is re-granted after each packet, with one IDLE cycle between packets.

## Timing
- **Reset values:** `s_tready = 0`, `m_tvalid = 0`, `m_tlast = 0`, `m_tdata = 0`, `m_tid = 0`, `trunc_pulse = 0`, `ptr = 0`, `grant = 0`, state IDLE.
- **Reset mid-packet:** reset aborts the packet and discards any held output beat; the next cycle starts in IDLE.
- **Grant latency:** one cycle from `s_tvalid` rising while in IDLE to `s_tready` rising.
- **Data latency:** one cycle from input acceptance to the beat appearing on `m_*`.
- **Throughput:** one beat per cycle while `m_tready` stays high. A packet of N beats occupies the arbiter for N+1 cycles (including the IDLE cycle).
- **Simultaneous requests in IDLE:** `ptr` sets priority. After a grant to source k, source k has the lowest priority in the next arbitration.
- **Stall release:** when `m_tready` rises during a stall, the held beat drains and the next input beat is accepted in the same cycle.

## Structure
- Shared package `axis_pkg`: the state encoding (`ST_IDLE`, `ST_BUSY`) and a `clog2` helper used when IDW or the counter width is computed outside synthesis-tool builtins.
- One sub-module: `rr_pick`, a combinational rotating priority finder. Inputs: the request vector and `ptr`. Outputs: the index of the winning requester and an `any` flag.
- The top level contains the FSM, the beat counter and the output register.

## Test plan
- **Single request:** source 2 sends a 3-beat packet 0x68, 0x69, 0x6A with `s_tlast` on 0x6A. Required: `s_tready[2]` rises 1 cycle after `s_tvalid`; `m_tdata` carries the three bytes with `m_tid = 2`; `m_tlast` is high on 0x6A only; `ptr` becomes 3.
- **Rotation:** sources 0, 1 and 3 all request continuously with 1-beat packets. Required: grant order 0, 1, 3, 0; no beat from another source appears inside any packet.
- **Backpressure:** hold `m_tready` low for 5 cycles mid-packet. Required: `m_tdata` and `m_tid` stay stable; `s_tready[grant]` is 0; no beat is lost or duplicated after release.
- **Truncation (MAX_BEATS = 4):** source 1 streams 6 beats with no `s_tlast`. Required: `m_tlast` and `trunc_pulse` are high on beat 4; beats 5 and 6 arrive as a new packet with `m_tid = 1`.
- **Reset mid-packet:** assert `reset` after beat 2 of a 4-beat packet. Required: all outputs return to 0 in the next cycle; the next arbitration starts from source 0.
- **End-to-end with the packer:** connect `m_*` to `axis_reg` (DW_IN = 8, DW_OUT = 32). Source 0 sends 0x01..0x04 with last. Required: one 32-bit word is produced and no extra words follow.
